// File: rtl/leaf_feeder_pkg.sv
// Shared sorter definitions: default record width, terminator record
// value and the feeder state encoding.
package leaf_feeder_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  // Terminator record appended after every leaf sequence.
  localparam logic [DEFAULT_DATA_WIDTH-1:0] TERM_RECORD = '0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_EMIT = 3'd2,
    ST_TERM = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/leaf_feeder.sv
// Leaf feeder: takes P-record beats and distributes them one record per
// cycle into LEAF_CNT leaf FIFOs. Each leaf receives LEN_SEQ records
// followed by TERM_CNT zero terminators.
//
// Handshake: a beat on i_data is taken on the rising edge where
// i_valid & o_ready are both high; o_ready is high only in FILL and does
// not depend on i_valid. The leaf write strobe is gated combinationally by
// that leaf's full flag, so a write never lands on a full FIFO and a
// stalled record is simply re-presented.
module leaf_feeder
  import leaf_feeder_pkg::*;
#(
  parameter int P          = 16,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LEAF_CNT   = 256,
  parameter int LEN_SEQ    = 16,
  parameter int TERM_CNT   = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [P*DATA_WIDTH-1:0] i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [LEAF_CNT-1:0]     i_fifo_full,
  output logic [LEAF_CNT-1:0]     o_fifo_write,
  output logic [DATA_WIDTH-1:0]   o_item,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [2:0]              o_state
);

  localparam int REC_W  = (P > 1) ? $clog2(P) : 1;
  localparam int LEAF_W = (LEAF_CNT > 1) ? $clog2(LEAF_CNT) : 1;
  localparam int SEQ_W  = $clog2(LEN_SEQ + 1);
  localparam int TERM_W = (TERM_CNT > 1) ? $clog2(TERM_CNT) : 1;

  localparam logic [REC_W-1:0]  REC_LAST  = REC_W'(P - 1);
  localparam logic [SEQ_W-1:0]  SEQ_STEP  = SEQ_W'(P);
  localparam logic [SEQ_W-1:0]  SEQ_FULL  = SEQ_W'(LEN_SEQ);
  localparam logic [TERM_W-1:0] TERM_LAST = TERM_W'(TERM_CNT - 1);
  localparam logic [LEAF_W-1:0] LEAF_LAST = LEAF_W'(LEAF_CNT - 1);

  if ((LEN_SEQ % P) != 0 || LEN_SEQ < P) begin : g_bad_len_seq
    $error("leaf_feeder: LEN_SEQ must be a non-zero multiple of P");
  end
  if (TERM_CNT < 1) begin : g_bad_term_cnt
    $error("leaf_feeder: TERM_CNT must be at least 1");
  end

  state_t                  state, state_next;
  logic [P*DATA_WIDTH-1:0] beat_buf;
  logic [REC_W-1:0]        rec_idx;
  logic [SEQ_W-1:0]        seq_cnt;
  logic [TERM_W-1:0]       term_cnt;
  logic [LEAF_W-1:0]       leaf_idx;
  logic                    wr;
  logic [SEQ_W-1:0]        seq_next;

  assign o_state  = state;
  assign seq_next = seq_cnt + SEQ_STEP;

  // A record leaves only while emitting and the current leaf has room.
  always_comb begin
    wr = 1'b0;
    if ((state == ST_EMIT || state == ST_TERM) && !i_rst)
      wr = ~i_fifo_full[leaf_idx];
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and output decode; reset forces every output low.
  always_comb begin
    state_next   = state;
    o_ready      = 1'b0;
    o_fifo_write = '0;
    o_item       = '0;
    o_busy       = (state != ST_IDLE);
    o_done       = 1'b0;
    case (state)
      ST_IDLE: if (i_start) state_next = ST_FILL;
      ST_FILL: begin
        o_ready = 1'b1;
        if (i_valid) state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (wr) begin
          o_fifo_write[leaf_idx] = 1'b1;
          o_item = beat_buf[rec_idx*DATA_WIDTH +: DATA_WIDTH];
          if (rec_idx == REC_LAST)
            state_next = (seq_next == SEQ_FULL) ? ST_TERM : ST_FILL;
        end
      end
      ST_TERM: begin
        if (wr) begin
          o_fifo_write[leaf_idx] = 1'b1;
          o_item = DATA_WIDTH'(TERM_RECORD);
          if (term_cnt == TERM_LAST)
            state_next = (leaf_idx == LEAF_LAST) ? ST_DONE : ST_FILL;
        end
      end
      ST_DONE: begin
        o_done     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (i_rst) begin
      o_ready      = 1'b0;
      o_fifo_write = '0;
      o_item       = '0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
    end
  end

  // Beat buffer and position counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_buf <= '0;
      rec_idx  <= '0;
      seq_cnt  <= '0;
      term_cnt <= '0;
      leaf_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            rec_idx  <= '0;
            seq_cnt  <= '0;
            term_cnt <= '0;
            leaf_idx <= '0;
          end
        end
        ST_FILL: if (i_valid) beat_buf <= i_data;
        ST_EMIT: begin
          if (wr) begin
            if (rec_idx == REC_LAST) begin
              rec_idx <= '0;
              seq_cnt <= seq_next;
            end else begin
              rec_idx <= rec_idx + 1'b1;
            end
          end
        end
        ST_TERM: begin
          if (wr) begin
            if (term_cnt == TERM_LAST) begin
              term_cnt <= '0;
              seq_cnt  <= '0;
              if (leaf_idx != LEAF_LAST) leaf_idx <= leaf_idx + 1'b1;
            end else begin
              term_cnt <= term_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_feeder.sv
// Directed-plus-random bench for leaf_feeder. The expected write stream is
// built from the beat table: leaf L gets beats 2L and 2L+1 record by
// record, then one zero terminator; o_done latency comes from cycle
// arithmetic plus the stall cycles each scenario inserts.
module tb_leaf_feeder;
  import leaf_feeder_pkg::*;

  localparam int P        = 16;
  localparam int DW       = 32;
  localparam int LEAF_CNT = 4;
  localparam int LEN_SEQ  = 32;
  localparam int TERM_CNT = 1;
  localparam int LW       = 2;
  localparam int NB       = LEAF_CNT * LEN_SEQ / P;
  localparam int BASE_LAT = 1 + LEAF_CNT * ((LEN_SEQ / P) * (P + 1) + TERM_CNT);

  logic                clk;
  logic                i_rst, i_start, i_valid;
  logic [P*DW-1:0]     i_data;
  logic                o_ready, o_busy, o_done;
  logic [LEAF_CNT-1:0] i_fifo_full, o_fifo_write;
  logic [DW-1:0]       o_item;
  logic [2:0]          o_state;

  leaf_feeder #(
    .P(P), .DATA_WIDTH(DW), .LEAF_CNT(LEAF_CNT), .LEN_SEQ(LEN_SEQ), .TERM_CNT(TERM_CNT)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_data(i_data),
    .i_valid(i_valid), .o_ready(o_ready), .i_fifo_full(i_fifo_full),
    .o_fifo_write(o_fifo_write), .o_item(o_item), .o_busy(o_busy),
    .o_done(o_done), .o_state(o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and bookkeeping
  logic [LW+DW-1:0] exp_q[$];
  logic [P*DW-1:0]  beats[NB];
  int beat_idx, cyc, start_cyc, done_cyc, done_seen, wr_total;
  int leaf_wr[LEAF_CNT];
  int pass_cnt, total_cnt;
  logic          s_ready, s_busy, s_done;
  logic [DW-1:0] s_item;
  logic [LEAF_CNT-1:0] s_wr;
  logic [2:0]    s_state;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: sample at negedge, score writes, then advance the beat
  // driver just after the rising edge.
  task automatic step();
    logic accept;
    logic [LW+DW-1:0] e;
    int wl;
    @(negedge clk);
    cyc++;
    s_ready = o_ready; s_busy = o_busy; s_done = o_done;
    s_item = o_item; s_wr = o_fifo_write; s_state = o_state;
    check("onehot", 64'($countones(o_fifo_write) <= 1), 64'd1);
    if (|o_fifo_write) begin
      wr_total++;
      wl = 0;
      for (int i = 0; i < LEAF_CNT; i++) if (o_fifo_write[i]) wl = i;
      if (exp_q.size() == 0) begin
        check("spurious_write", 64'(exp_q.size() != 0), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("leaf", 64'(wl), 64'(e[DW +: LW]));
        check("item", 64'(o_item), 64'(e[DW-1:0]));
      end
      leaf_wr[wl]++;
    end
    if (o_done) begin
      done_seen++;
      done_cyc = cyc;
    end
    accept = i_valid && o_ready;
    @(posedge clk);
    #1;
    if (accept) begin
      beat_idx++;
      if (beat_idx < NB) i_data = beats[beat_idx];
    end
  endtask

  task automatic prep(input bit ascending);
    int base;
    logic [DW-1:0] r;
    base = $urandom_range(1, 1000);
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < P; k++) begin
        if (ascending) r = DW'(base + b * P + k);
        else           r = $urandom;
        beats[b][k*DW +: DW] = r;
      end
    exp_q.delete();
    for (int l = 0; l < LEAF_CNT; l++) begin
      for (int b = 0; b < LEN_SEQ / P; b++)
        for (int k = 0; k < P; k++)
          exp_q.push_back({LW'(l), beats[l*(LEN_SEQ/P) + b][k*DW +: DW]});
      for (int t = 0; t < TERM_CNT; t++) exp_q.push_back({LW'(l), DW'(0)});
    end
    for (int l = 0; l < LEAF_CNT; l++) leaf_wr[l] = 0;
    beat_idx  = 0;
    i_data    = beats[0];
    done_seen = 0;
    done_cyc  = -1;
  endtask

  task automatic kick();
    i_start = 1'b1;
    step();
    start_cyc = cyc;
    i_start = 1'b0;
  endtask

  task automatic wait_writes(input int leaf, input int n);
    int k;
    k = 0;
    while (leaf_wr[leaf] < n && k < 3000) begin
      step();
      k++;
    end
    check("wait_writes", 64'(leaf_wr[leaf] >= n), 64'd1);
  endtask

  task automatic finish_load(input string tag, input int lat);
    int n;
    n = 0;
    while (done_seen == 0 && n < 3000) begin
      step();
      n++;
    end
    check({tag, "_done_latency"}, 64'(done_cyc - start_cyc), 64'(lat));
    repeat (3) step();
    check({tag, "_done_once"}, 64'(done_seen), 64'd1);
    check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle_busy"}, 64'(s_busy), 64'd0);
  endtask

  initial begin
    int w0, r;
    pass_cnt = 0; total_cnt = 0; cyc = 0; wr_total = 0;
    i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_fifo_full = '0;
    i_data = '0; beat_idx = 0; done_seen = 0; done_cyc = -1; start_cyc = 0;
    for (int l = 0; l < LEAF_CNT; l++) leaf_wr[l] = 0;
    #1;
    step();
    step();
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_write", 64'(s_wr), 64'd0);
    check("rst_item", 64'(s_item), 64'd0);
    check("rst_busy", 64'(s_busy), 64'd0);
    check("rst_done", 64'(s_done), 64'd0);
    check("rst_state", 64'(s_state), 64'(ST_IDLE));
    i_rst = 1'b0;
    i_valid = 1'b1;
    step();

    // ascending beats, no back-pressure
    prep(1'b1);
    kick();
    finish_load("plain", BASE_LAT);
    for (int l = 0; l < LEAF_CNT; l++)
      check("plain_leaf_count", 64'(leaf_wr[l]), 64'(LEN_SEQ + TERM_CNT));

    // leaf 1 full for 10 cycles while record 5 is pending
    prep(1'b0);
    kick();
    wait_writes(1, 5);
    i_fifo_full[1] = 1'b1;
    w0 = wr_total;
    repeat (10) step();
    check("stall_no_write", 64'(wr_total - w0), 64'd0);
    i_fifo_full[1] = 1'b0;
    step();
    check("stall_rec5_written", 64'(leaf_wr[1]), 64'd6);
    check("stall_rec5_item", 64'(s_item), 64'(beats[2][5*DW +: DW]));
    finish_load("stall", BASE_LAT + 10);

    // a foreign leaf's full flag must not disturb leaf 0
    prep(1'b0);
    i_fifo_full = 4'b0100;
    kick();
    wait_writes(0, LEN_SEQ + TERM_CNT);
    i_fifo_full = '0;
    check("foreign_leaf0_count", 64'(leaf_wr[0]), 64'(LEN_SEQ + TERM_CNT));
    finish_load("foreign", BASE_LAT);

    // start pulse while busy, then 7-cycle valid gap before leaf 3 beat 2
    prep(1'b0);
    kick();
    wait_writes(1, 3);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    wait_writes(3, P);
    i_valid = 1'b0;
    w0 = wr_total;
    r = 0;
    repeat (7) begin
      step();
      if (s_ready) r++;
    end
    check("gap_ready_high", 64'(r), 64'd7);
    check("gap_no_write", 64'(wr_total - w0), 64'd0);
    i_valid = 1'b1;
    finish_load("gap", BASE_LAT + 7);

    // reset during leaf 2 emission aborts the load
    prep(1'b0);
    kick();
    wait_writes(2, 3);
    i_rst = 1'b1;
    step();
    check("abort_ready", 64'(s_ready), 64'd0);
    check("abort_write", 64'(s_wr), 64'd0);
    check("abort_item", 64'(s_item), 64'd0);
    check("abort_busy", 64'(s_busy), 64'd0);
    check("abort_done", 64'(s_done), 64'd0);
    step();
    check("abort_state", 64'(s_state), 64'(ST_IDLE));
    i_rst = 1'b0;
    exp_q.delete();
    w0 = wr_total;
    repeat (20) step();
    check("abort_no_write", 64'(wr_total - w0), 64'd0);
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_idle", 64'(s_busy), 64'd0);
    prep(1'b1);
    kick();
    finish_load("reload", BASE_LAT);
    check("reload_leaf0_count", 64'(leaf_wr[0]), 64'(LEN_SEQ + TERM_CNT));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
